// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input-conditioning slice: debounce
// window default, channel indices and the 4-bit channel vector type.
package stopwatch_pkg;

  // 10 ms at 100 MHz
  localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;

  localparam int NUM_CH   = 4;
  localparam int CH_SEL   = 0;
  localparam int CH_ADJ   = 1;
  localparam int CH_PAUSE = 2;
  localparam int CH_CLEAR = 3;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Width of the stability counter; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-flop synchroniser, stability counter, debounced level
// and a registered one-cycle rise pulse trailing the level by one clock.
module debounce_ch
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic rise_next_o
);

  localparam int unsigned    CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic          db_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Accept a new level only after it has differed from db for DB_CYCLES
  // consecutive cycles; any return to the current level restarts the window.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // The rise pulse is built from the already-registered level so it appears
  // one clock after db changes and lasts exactly one cycle.
  assign rise_d = db_q & ~db_dly_q;

  // Debounce state, delayed level copy and rise pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q     <= 1'b0;
      cnt_q    <= '0;
      db_dly_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      db_dly_q <= db_q;
      rise_q   <= rise_d;
    end
  end

  assign db_o        = db_q;
  assign rise_o      = rise_q;
  assign rise_next_o = rise_d;

endmodule

// File: rtl/stopwatch_inputs.sv
// Input conditioning for the stopwatch core: four debounced channels plus
// the pause state. Build option PAUSE_TOGGLE_EN: when defined pause is a
// toggle register (clear forces it low); otherwise pause follows the
// debounced pause button level.
module stopwatch_inputs
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic MegaClk,
  input  logic reset_n,
  input  logic sw_sel_raw,
  input  logic sw_adj_raw,
  input  logic btn_pause_raw,
  input  logic btn_clear_raw,
  output logic sel,
  output logic adj,
  output logic pause,
  output logic clear
);

  ch_vec_t raw;
  ch_vec_t db;
  ch_vec_t rise;
  ch_vec_t rise_next;

  assign raw[CH_SEL]   = sw_sel_raw;
  assign raw[CH_ADJ]   = sw_adj_raw;
  assign raw[CH_PAUSE] = btn_pause_raw;
  assign raw[CH_CLEAR] = btn_clear_raw;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk_i       (MegaClk),
      .rst_ni      (reset_n),
      .raw_i       (raw[g]),
      .db_o        (db[g]),
      .rise_o      (rise[g]),
      .rise_next_o (rise_next[g])
    );
  end

  assign sel   = db[CH_SEL];
  assign adj   = db[CH_ADJ];
  assign clear = rise[CH_CLEAR];

`ifdef PAUSE_TOGGLE_EN
  logic pause_q, pause_d;

  // Toggle on each accepted pause press; a simultaneous clear wins. Uses the
  // next-cycle rise values so pause changes together with the clear pulse.
  always_comb begin
    pause_d = pause_q;
    if (rise_next[CH_CLEAR]) begin
      pause_d = 1'b0;
    end else if (rise_next[CH_PAUSE]) begin
      pause_d = ~pause_q;
    end
  end

  // Pause state register.
  always_ff @(posedge MegaClk or negedge reset_n) begin
    if (!reset_n) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause_d;
    end
  end

  assign pause = pause_q;

  logic unused_ok;
  assign unused_ok = ^{rise[CH_SEL], rise[CH_ADJ], rise[CH_PAUSE], db[CH_PAUSE],
                       db[CH_CLEAR], rise_next[CH_SEL], rise_next[CH_ADJ]};
`else
  assign pause = db[CH_PAUSE];

  logic unused_ok;
  assign unused_ok = ^{rise[CH_SEL], rise[CH_ADJ], rise[CH_PAUSE], db[CH_CLEAR],
                       rise_next};
`endif

endmodule

// File: tb/tb_stopwatch_inputs.sv
// Bench for stopwatch_inputs with DB_CYCLES=4: table vectors, hand-written
// latency/bounce/priority sequences and randomized stimulus against a
// sample-history reference model.
module tb_stopwatch_inputs;

  localparam int DB = 4;
`ifdef PAUSE_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_raw = 1'b0, adj_raw = 1'b0, pause_raw = 1'b0, clear_raw = 1'b0;
  logic sel, adj, pause, clear;
  wire [3:0] outs = {clear, pause, adj, sel};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  stopwatch_inputs #(.DB_CYCLES(DB)) dut (
    .MegaClk       (clk),
    .reset_n       (rst_n),
    .sw_sel_raw    (sel_raw),
    .sw_adj_raw    (adj_raw),
    .btn_pause_raw (pause_raw),
    .btn_clear_raw (clear_raw),
    .sel           (sel),
    .adj           (adj),
    .pause         (pause),
    .clear         (clear)
  );

  // Reference model: keeps the raw samples seen at each edge. A channel's
  // debounced level flips at edge e when the samples taken at edges
  // e-DB-1 .. e-2 all differ from it (two edges of synchroniser delay).
  logic [3:0] hist[$];
  logic [3:0] mdb = '0, mpend = '0, mrise = '0;
  logic       mpause = 1'b0;

  task automatic model_edge();
    logic [3:0] newdb, s;
    int n;
    bit diff;
    if (!rst_n) begin
      hist.delete();
      mdb = '0; mpend = '0; mrise = '0; mpause = 1'b0;
      return;
    end
    hist.push_back({clear_raw, pause_raw, adj_raw, sel_raw});
    if (hist.size() > 16) void'(hist.pop_front());
    n = hist.size();
    newdb = mdb;
    for (int ch = 0; ch < 4; ch++) begin
      diff = 1'b1;
      for (int k = n - DB - 2; k <= n - 3; k++) begin
        s = (k < 0) ? 4'b0000 : hist[k];
        if (s[ch] == mdb[ch]) diff = 1'b0;
      end
      if (diff) newdb[ch] = ~mdb[ch];
    end
    mrise = mpend;
    mpend = newdb & ~mdb;
    mdb   = newdb;
    if (TOG) begin
      if (mrise[3]) mpause = 1'b0;
      else if (mrise[2]) mpause = ~mpause;
    end else begin
      mpause = mdb[2];
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("model", int'(outs), int'({mrise[3], mpause, mdb[1], mdb[0]}));
  endtask

  task automatic set_raw(input logic [3:0] r);
    {clear_raw, pause_raw, adj_raw, sel_raw} = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_raw(4'b0000);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  typedef struct {
    logic [3:0] raw;
    int         cycles;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int first, pulses, pulse_edge, early;

    // Reset with toggling inputs, then release with sel held high.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_raw(4'($urandom));
      step();
      check("reset_outs", int'(outs), 0);
    end
    set_raw(4'b0001);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("sel_latency", int'(sel), (e >= 6) ? 1 : 0);
    end

    // Table-driven vectors.
    tbl[0] = '{4'b0000, 8, 4'b0000};
    tbl[1] = '{4'b0001, 8, 4'b0001};
    tbl[2] = '{4'b0011, 8, 4'b0011};
    tbl[3] = '{4'b0010, 2, 4'b0011};
    tbl[4] = '{4'b0011, 8, 4'b0011};
    tbl[5] = '{4'b0111, 8, 4'b0111};
    tbl[6] = '{4'b0011, 8, TOG ? 4'b0111 : 4'b0011};
    tbl[7] = '{4'b1011, 8, 4'b0011};
    tbl[8] = '{4'b0000, 8, 4'b0000};
    do_reset();
    for (int v = 0; v < 9; v++) begin
      set_raw(tbl[v].raw);
      for (int c = 0; c < tbl[v].cycles; c++) step();
      check($sformatf("table%0d", v), int'(outs), int'(tbl[v].exp));
    end

    // Clean press, release, second press of pause.
    do_reset();
    pause_raw = 1'b1;
    first = -1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (pause && first < 0) first = e;
    end
    check("pause_first_edge", first, TOG ? 7 : 6);
    check("pause_held", int'(pause), 1);
    pause_raw = 1'b0;
    repeat (10) step();
    check("pause_after_release", int'(pause), TOG ? 1 : 0);
    pause_raw = 1'b1;
    repeat (10) step();
    check("pause_second_press", int'(pause), TOG ? 0 : 1);
    pause_raw = 1'b0;
    repeat (10) step();

    // Bounce on clear: 3 high, 1 low, 10 high.
    do_reset();
    early = 0;
    clear_raw = 1'b1;
    repeat (3) begin step(); if (clear) early++; end
    clear_raw = 1'b0;
    step(); if (clear) early++;
    clear_raw = 1'b1;
    pulses = 0;
    pulse_edge = -1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 11) clear_raw = 1'b0;
      step();
      if (clear) begin pulses++; pulse_edge = e; end
    end
    check("bounce_early_pulses", early, 0);
    check("bounce_pulse_count", pulses, 1);
    check("bounce_pulse_edge", pulse_edge, 7);

    // Clear and pause pressed together while pause is active.
    do_reset();
    if (TOG) begin
      pause_raw = 1'b1;
      repeat (10) step();
      pause_raw = 1'b0;
      repeat (10) step();
      check("prio_setup", int'(pause), 1);
    end
    pause_raw = 1'b1;
    clear_raw = 1'b1;
    repeat (6) step();
    check("prio_e6_pause", int'(pause), 1);
    step();
    check("prio_e7_clear", int'(clear), 1);
    check("prio_e7_pause", int'(pause), TOG ? 0 : 1);
    step();
    check("prio_e8_clear", int'(clear), 0);
    check("prio_e8_pause", int'(pause), TOG ? 0 : 1);
    set_raw(4'b0000);
    repeat (10) step();

    // Level channel: adj glitch rejected, steady adj accepted, others untouched.
    do_reset();
    adj_raw = 1'b1;
    repeat (2) step();
    adj_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check("adj_glitch", int'(adj), 0);
    end
    adj_raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("adj_latency", int'(adj), (e >= 6) ? 1 : 0);
      check("adj_side", int'({clear, pause}), 0);
    end

    // Randomized stimulus: slow phase (mostly accepted), fast phase (bouncy),
    // with occasional asynchronous resets mid-count.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = (i < 2000) ? 6 : 2;
      if ($urandom_range(0, p - 1) == 0) sel_raw   = ~sel_raw;
      if ($urandom_range(0, p - 1) == 0) adj_raw   = ~adj_raw;
      if ($urandom_range(0, p - 1) == 0) pause_raw = ~pause_raw;
      if ($urandom_range(0, p - 1) == 0) clear_raw = ~clear_raw;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
